// File: rtl/disp_arbiter.sv
// Round-robin arbiter that lets one of three requesters own a 4-digit
// seven-segment display for at least HOLD_CYC cycles before handing over.
module disp_arbiter #(
    parameter int HOLD_CYC = 50_000_000,
    parameter int LZB      = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [15:0] x,
    output logic [3:0]  aen,
    output logic [2:0]  gnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [25:0] HOLD_LOAD = 26'(HOLD_CYC - 1);

    state_t      state, state_nxt;
    logic [15:0] x_nxt;
    logic [3:0]  aen_nxt;
    logic [2:0]  gnt_nxt;
    logic [25:0] hold_cnt, hold_nxt;
    logic [1:0]  last, last_nxt;

    logic [1:0]  cand0, cand1, cand2, pick;
    logic [2:0]  pick_onehot;
    logic [15:0] shown;
    logic        granted_req, others_req;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    function automatic logic req_bit(input logic [2:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    req_bit = r[0];
            2'd1:    req_bit = r[1];
            2'd2:    req_bit = r[2];
            default: req_bit = 1'b0;
        endcase
    endfunction

    // A digit stays lit once it or any more significant digit is nonzero.
    function automatic logic [3:0] digit_enables(input logic [15:0] v);
        logic [3:0] en;
        if (LZB != 0) begin
            en[3] = |v[15:12];
            en[2] = en[3] | (|v[11:8]);
            en[1] = en[2] | (|v[7:4]);
            en[0] = 1'b1;
        end else begin
            en = 4'hF;
        end
        return en;
    endfunction

    always_comb begin
        cand0 = rr_next(last);
        cand1 = rr_next(cand0);
        cand2 = rr_next(cand1);
        if (req_bit(req, cand0))
            pick = cand0;
        else if (req_bit(req, cand1))
            pick = cand1;
        else
            pick = cand2;
        pick_onehot = 3'b001 << pick;
    end

    always_comb begin
        case (gnt)
            3'b010:  shown = val1;
            3'b100:  shown = val2;
            default: shown = val0;
        endcase
        granted_req = |(req & gnt);
        others_req  = |(req & ~gnt);
    end

    // Next-state and next-output decode; every register gets its next value here.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        aen_nxt   = aen;
        gnt_nxt   = gnt;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                x_nxt   = 16'h0000;
                aen_nxt = 4'b0000;
                gnt_nxt = 3'b000;
                if (req != 3'b000) begin
                    state_nxt = SHOW;
                    gnt_nxt   = pick_onehot;
                    hold_nxt  = HOLD_LOAD;
                    last_nxt  = pick;
                end
            end
            SHOW: begin
                x_nxt    = shown;
                aen_nxt  = digit_enables(shown);
                hold_nxt = (hold_cnt != 26'd0) ? hold_cnt - 26'd1 : 26'd0;
                if (!granted_req || (hold_cnt == 26'd0 && others_req)) begin
                    aen_nxt = 4'b0000;
                    gnt_nxt = 3'b000;
                    if (others_req) begin
                        state_nxt = SWITCH;
                    end else begin
                        state_nxt = IDLE;
                        x_nxt     = 16'h0000;
                    end
                end
            end
            SWITCH: begin
                aen_nxt = 4'b0000;
                if (req == 3'b000) begin
                    state_nxt = IDLE;
                    x_nxt     = 16'h0000;
                    gnt_nxt   = 3'b000;
                end else begin
                    state_nxt = SHOW;
                    gnt_nxt   = pick_onehot;
                    hold_nxt  = HOLD_LOAD;
                    last_nxt  = pick;
                end
            end
            default: begin
                state_nxt = IDLE;
                x_nxt     = 16'h0000;
                aen_nxt   = 4'b0000;
                gnt_nxt   = 3'b000;
            end
        endcase
    end

    // last resets to 2 so that requester 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= IDLE;
            x        <= 16'h0000;
            aen      <= 4'b0000;
            gnt      <= 3'b000;
            hold_cnt <= 26'd0;
            last     <= 2'd2;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            aen      <= aen_nxt;
            gnt      <= gnt_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter: two instances (hold 4 with blanking,
// hold 1 without) compared every cycle against a behavioural display model.
module tb_disp_arbiter;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 1;

    typedef struct packed {
        logic [15:0] x;
        logic [3:0]  aen;
        logic [2:0]  gnt;
        logic        busy;
    } out_t;

    typedef struct packed {
        out_t a;
        out_t b;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [2:0]  req;
    logic [15:0] val0, val1, val2;
    logic [15:0] xa, xb;
    logic [3:0]  aena, aenb;
    logic [2:0]  gnta, gntb;
    logic        busya, busyb;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    exp_t sb_q[$];

    // model state per instance: phase 0 idle, 1 showing, 2 handing over
    int   phase[2];
    int   owner[2];
    int   last_w[2];
    int   elapsed[2];
    out_t mo[2];
    int   hold_of[2];
    bit   lzb_of[2];

    always #5 clk = ~clk;

    disp_arbiter #(.HOLD_CYC(HOLD_A), .LZB(1)) dut_a (
        .clk(clk), .clr_n(clr_n), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .x(xa), .aen(aena), .gnt(gnta), .busy(busya)
    );

    disp_arbiter #(.HOLD_CYC(HOLD_B), .LZB(0)) dut_b (
        .clk(clk), .clr_n(clr_n), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .x(xb), .aen(aenb), .gnt(gntb), .busy(busyb)
    );

    function automatic logic [15:0] val_of(input int i);
        if (i == 0) return val0;
        if (i == 1) return val1;
        return val2;
    endfunction

    function automatic int rr_pick(input logic [2:0] r, input int from_last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (from_last + k) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Light as many digits as the number has significant hex digits (at least one).
    function automatic logic [3:0] lit_digits(input logic [15:0] v);
        int top;
        top = 0;
        for (int k = 0; k < 4; k++)
            if (((v >> (4 * k)) & 16'h000F) != 16'h0000) top = k;
        return 4'((1 << (top + 1)) - 1);
    endfunction

    task automatic grant_to(input int m);
        int w;
        w          = rr_pick(req, last_w[m]);
        owner[m]   = w;
        last_w[m]  = w;
        elapsed[m] = 0;
        phase[m]   = 1;
        mo[m].gnt  = 3'(1 << w);
        mo[m].aen  = 4'b0000;
    endtask

    task automatic model_step(input int m);
        logic [2:0]  others;
        logic [15:0] v;
        if (!clr_n) begin
            phase[m]  = 0;
            last_w[m] = 2;
            mo[m]     = '0;
            return;
        end
        case (phase[m])
            0: begin
                mo[m] = '0;
                if (req != 3'b000) grant_to(m);
            end
            1: begin
                elapsed[m]++;
                v      = val_of(owner[m]);
                others = req & ~3'(1 << owner[m]);
                if (!req[owner[m]] || (elapsed[m] >= hold_of[m] && others != 3'b000)) begin
                    if (others != 3'b000) begin
                        phase[m]  = 2;
                        mo[m].x   = v;
                        mo[m].aen = 4'b0000;
                        mo[m].gnt = 3'b000;
                    end else begin
                        phase[m] = 0;
                        mo[m]    = '0;
                    end
                end else begin
                    mo[m].x   = v;
                    mo[m].aen = lzb_of[m] ? lit_digits(v) : 4'hF;
                end
            end
            default: begin
                if (req == 3'b000) begin
                    phase[m] = 0;
                    mo[m]    = '0;
                end else begin
                    grant_to(m);
                end
            end
        endcase
        mo[m].busy = (phase[m] != 0);
    endtask

    // Reference model advances on every edge and queues what each DUT should show.
    always @(posedge clk) begin
        exp_t e;
        model_step(0);
        model_step(1);
        e.a = mo[0];
        e.b = mo[1];
        sb_q.push_back(e);
        cycle++;
    end

    task automatic check_output(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got x=%h aen=%b gnt=%b busy=%b required x=%h aen=%b gnt=%b busy=%b",
                     name, cycle, got.x, got.aen, got.gnt, got.busy,
                     want.x, want.aen, want.gnt, want.busy);
        end
    endtask

    // Monitor samples shortly after each edge and pops the matching expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_output("dut_a", {xa, aena, gnta, busya}, e.a);
            check_output("dut_b", {xb, aenb, gntb, busyb}, e.b);
        end
    end

    function automatic logic [15:0] rand_val();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return r & 16'h000F;
            2:       return r & 16'h00FF;
            3:       return r & 16'h0FFF;
            4:       return 16'h0100;
            default: return r;
        endcase
    endfunction

    task automatic apply_stimulus(input logic [2:0] r, input int cycles, input bit rand_vals);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            req = r;
            if (rand_vals) begin
                val0 = rand_val();
                val1 = rand_val();
                val2 = rand_val();
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        bit found;
        hold_of = '{HOLD_A, HOLD_B};
        lzb_of  = '{1'b1, 1'b0};
        phase   = '{0, 0};
        last_w  = '{2, 2};
        owner   = '{0, 0};
        elapsed = '{0, 0};
        mo[0]   = '0;
        mo[1]   = '0;
        clr_n = 1'b0;
        req   = 3'b000;
        val0  = 16'h0000;
        val1  = 16'h0000;
        val2  = 16'h0000;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        val1 = 16'h0042;
        apply_stimulus(3'b010, 6, 1'b0);
        apply_stimulus(3'b000, 3, 1'b0);

        apply_stimulus(3'b111, 32, 1'b1);
        apply_stimulus(3'b000, 3, 1'b0);

        apply_stimulus(3'b001, 20, 1'b1);
        val0 = 16'h0000;
        apply_stimulus(3'b001, 3, 1'b0);
        val0 = 16'h0100;
        apply_stimulus(3'b001, 3, 1'b0);
        apply_stimulus(3'b000, 2, 1'b0);

        // early release: requester 0 drops during its second shown cycle
        reset_pulse();
        apply_stimulus(3'b001, 2, 1'b1);
        apply_stimulus(3'b100, 8, 1'b1);
        apply_stimulus(3'b000, 2, 1'b0);

        // reset while handing over, then 1 and 2 compete from a fresh start
        apply_stimulus(3'b111, 1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (phase[0] == 2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL switch_reached got phase=%0d required phase=2", phase[0]);
        end
        clr_n = 1'b0;
        req   = 3'b110;
        @(negedge clk);
        clr_n = 1'b1;
        apply_stimulus(3'b110, 12, 1'b1);

        // random traffic with sticky requests and rare resets
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req = 3'($urandom);
            val0  = rand_val();
            val1  = rand_val();
            val2  = rand_val();
            clr_n = ($urandom_range(0, 149) != 0);
        end
        clr_n = 1'b1;
        apply_stimulus(3'b000, 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
